// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MULDIV_XLEN  = 32;
  localparam int unsigned MULDIV_CNT_W = $clog2(MULDIV_XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negator of parameterised width.
module muldiv_negate #(
  parameter int unsigned Width = 32
) (
  input  logic             i_neg,
  input  logic [Width-1:0] i_val,
  output logic [Width-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + Width'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// MULDIV_SPECIAL_FAST_EN: divide-by-zero / signed-overflow skip straight to DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = MULDIV_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_opa,
  input  logic [XLEN-1:0] i_opb,
  input  logic [5:0]      i_rd,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_wb_en,
  output logic [5:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data
);

  localparam int unsigned CntW = $clog2(XLEN);

  muldiv_state_t     r_state, w_state_d;
  logic [CntW-1:0]   r_cnt;
  logic [2:0]        r_op;
  logic [5:0]        r_rd;
  logic [XLEN-1:0]   r_m;
  logic [2*XLEN-1:0] r_acc;
  logic              r_neg;
  logic              r_spec;
  logic [XLEN-1:0]   r_spec_data;
  logic [XLEN-1:0]   r_wb_data;

  logic              w_is_div, w_is_rem, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
  logic              w_div0, w_ovf, w_fast, w_accept;
  logic [XLEN-1:0]   w_abs_a, w_abs_b, w_spec_data, w_result;
  logic [XLEN:0]     w_sum, w_shift, w_trial;
  logic [2*XLEN-1:0] w_mul_next, w_div_next, w_fix_in, w_fix_out;

  assign w_is_div = i_funct3[2];
  assign w_is_rem = i_funct3[2] & i_funct3[1];

  always_comb begin
    w_sgn_a = 1'b0;
    w_sgn_b = 1'b0;
    case (i_funct3)
      F3_MULH, F3_DIV, F3_REM: begin
        w_sgn_a = 1'b1;
        w_sgn_b = 1'b1;
      end
      F3_MULHSU: w_sgn_a = 1'b1;
      default: ;
    endcase
  end

  assign w_neg_a = w_sgn_a & i_opa[XLEN-1];
  assign w_neg_b = w_sgn_b & i_opb[XLEN-1];

  muldiv_negate #(.Width(XLEN)) u_abs_a (.i_neg(w_neg_a), .i_val(i_opa), .o_val(w_abs_a));
  muldiv_negate #(.Width(XLEN)) u_abs_b (.i_neg(w_neg_b), .i_val(i_opb), .o_val(w_abs_b));

  // Special cases are resolved at start so the datapath result is simply overridden in FIX.
  assign w_div0 = w_is_div & (i_opb == '0);
  assign w_ovf  = w_is_div & ~i_funct3[0] & (i_opa == {1'b1, {(XLEN-1){1'b0}}}) &
                  (i_opb == '1);

  always_comb begin
    w_spec_data = '0;
    if (w_div0)     w_spec_data = w_is_rem ? i_opa : '1;
    else if (w_ovf) w_spec_data = w_is_rem ? '0 : i_opa;
  end

`ifdef MULDIV_SPECIAL_FAST_EN
  assign w_fast = w_div0 | w_ovf;
`else
  assign w_fast = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) & i_start & ~i_flush;

  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

  // Remainder in the upper half, dividend/quotient bits in the lower half.
  assign w_shift    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_trial    = w_shift - {1'b0, r_m};
  assign w_div_next = w_trial[XLEN] ? {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                    : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_fix_in = r_op[2] ?
      {{XLEN{1'b0}}, (r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0])} : r_acc;

  muldiv_negate #(.Width(2*XLEN)) u_fix (.i_neg(r_neg), .i_val(w_fix_in), .o_val(w_fix_out));

  assign w_result = (r_op[2] || r_op[1:0] == 2'b00) ? w_fix_out[XLEN-1:0]
                                                     : w_fix_out[2*XLEN-1:XLEN];

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_state_d = w_fast ? DONE : CALC;
      CALC: begin
        if (i_flush)                         w_state_d = IDLE;
        else if (r_cnt == CntW'(XLEN - 1))   w_state_d = FIX;
      end
      FIX:  w_state_d = i_flush ? IDLE : DONE;
      DONE: w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_op        <= '0;
      r_rd        <= '0;
      r_m         <= '0;
      r_acc       <= '0;
      r_neg       <= 1'b0;
      r_spec      <= 1'b0;
      r_spec_data <= '0;
      r_wb_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op        <= i_funct3;
            r_rd        <= i_rd;
            r_neg       <= w_is_rem ? w_neg_a : (w_neg_a ^ w_neg_b);
            r_spec      <= w_div0 | w_ovf;
            r_spec_data <= w_spec_data;
            r_cnt       <= '0;
            r_m         <= w_is_div ? w_abs_b : w_abs_a;
            r_acc       <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
            if (w_fast) r_wb_data <= w_spec_data;
          end
        end
        CALC: begin
          r_cnt <= r_cnt + CntW'(1);
          r_acc <= r_op[2] ? w_div_next : w_mul_next;
        end
        FIX: begin
          if (!i_flush) r_wb_data <= r_spec ? r_spec_data : w_result;
        end
        default: ;
      endcase
    end
  end

  assign o_busy    = (r_state == CALC) | (r_state == FIX);
  assign o_done    = (r_state == DONE);
  assign o_wb_en   = o_done & (r_rd != '0);
  assign o_wb_rd   = r_rd;
  assign o_wb_data = r_wb_data;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expectations, a monitor checks on done.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_SPECIAL_FAST_EN
  localparam int SpecLat = 1;
`else
  localparam int SpecLat = 34;
`endif
  localparam int NormLat = 34;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic [5:0]  rd = '0;
  logic        busy, done, wb_en;
  logic [5:0]  wb_rd;
  logic [31:0] wb_data;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  rd;
    logic        wen;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_flush(flush), .i_funct3(f3),
    .i_opa(opa), .i_opb(opb), .i_rd(rd), .o_busy(busy), .o_done(done), .o_wb_en(wb_en),
    .o_wb_rd(wb_rd), .o_wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no completion");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_data", 64'(wb_data), 64'(e.data));
        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
        chk("wb_en", 64'(wb_en), 64'(e.wen));
      end
    end
  end

  // Start drives in cycle 0; cycle n is sampled on the n-th following negedge.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] r, input logic [31:0] exp,
                        input int lat, input bit inj);
    exp_t e;
    int   cyc;
    bit   got;
    bit   busy_ok;
    e.data = exp;
    e.rd   = r;
    e.wen  = (r != 6'd0);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; f3 = f; opa = a; opb = b; rd = r;
    cyc = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && cyc < 80) begin
      @(negedge clk);
      cyc++;
      start = inj && (cyc == 5);
      if (inj && cyc == 5) begin
        f3 = F3_MULHU; opa = 32'd3; opb = 32'd3; rd = 6'd9;
      end
      if (done) begin
        got = 1'b1;
        chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
    start = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done in %0d cycles want done at cycle %0d", name, cyc,
               lat);
      sb.delete();
    end else begin
      chk({name, "_latency"}, 64'(cyc), 64'(lat));
      chk({name, "_busy_run"}, 64'(busy_ok), 64'd1);
    end
  endtask

  initial begin
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul",      F3_MUL,    32'd7,        32'hFFFFFFFD, 6'd5,  32'hFFFFFFEB, NormLat, 0);
    run_op("mulhu",    F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 6'd1,  32'hFFFFFFFE, NormLat, 0);
    run_op("mulh",     F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 6'd2,  32'h00000000, NormLat, 0);
    run_op("mulhsu",   F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd3,  32'hFFFFFFFF, NormLat, 0);
    run_op("div",      F3_DIV,    32'hFFFFFFF9, 32'd2,        6'd4,  32'hFFFFFFFD, NormLat, 0);
    run_op("rem",      F3_REM,    32'hFFFFFFF9, 32'd2,        6'd6,  32'hFFFFFFFF, NormLat, 0);
    run_op("divu",     F3_DIVU,   32'd100,      32'd7,        6'd7,  32'd14,       NormLat, 0);
    run_op("remu",     F3_REMU,   32'd100,      32'd7,        6'd8,  32'd2,        NormLat, 0);
    run_op("divu0",    F3_DIVU,   32'd5,        32'd0,        6'd10, 32'hFFFFFFFF, SpecLat, 0);
    run_op("remu0",    F3_REMU,   32'd5,        32'd0,        6'd11, 32'd5,        SpecLat, 0);
    run_op("div_ovf",  F3_DIV,    32'h80000000, 32'hFFFFFFFF, 6'd12, 32'h80000000, SpecLat, 0);
    run_op("rem_ovf",  F3_REM,    32'h80000000, 32'hFFFFFFFF, 6'd13, 32'd0,        SpecLat, 0);
    run_op("div0_s",   F3_DIV,    32'hFFFFFFF9, 32'd0,        6'd14, 32'hFFFFFFFF, SpecLat, 0);
    run_op("rem0_s",   F3_REM,    32'hFFFFFFF9, 32'd0,        6'd15, 32'hFFFFFFF9, SpecLat, 0);
    run_op("mul_rd0",  F3_MUL,    32'd6,        32'd7,        6'd0,  32'd42,       NormLat, 0);
    run_op("inj",      F3_DIVU,   32'd100,      32'd7,        6'd16, 32'd14,       NormLat, 1);

    // Flush raised in cycle 10 of an op that must never complete.
    @(negedge clk);
    start = 1'b1; f3 = F3_MUL; opa = 32'd3; opb = 32'd4; rd = 6'd17;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    run_op("post_flush", F3_MUL, 32'd3, 32'd5, 6'd18, 32'd15, NormLat, 0);

    // Reset asserted mid-operation in cycle 20.
    @(negedge clk);
    start = 1'b1; f3 = F3_DIVU; opa = 32'd1000; opb = 32'd3; rd = 6'd19;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_wb_en", 64'(wb_en), 64'd0);
    chk("arst_wb_rd", 64'(wb_rd), 64'd0);
    chk("arst_wb_data", 64'(wb_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    run_op("post_rst", F3_MULHU, 32'h80000000, 32'd4, 6'd20, 32'd2, NormLat, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit for the single-cycle CPU. It takes the two register-file read values, `rv1` and `rv2`, plus the destination index. It computes one of the eight M-extension operations over multiple cycles and holds the core stalled via `busy`. On completion it drives a one-cycle write-back (`wb_en`/`wb_rd`/`wb_data`) that feeds the register file's `regwrite`/`rd`/`rf_indata` inputs.

## Interface
- `XLEN`, 32: operand/result width; iteration count equals `XLEN`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `flush`  in  1  abort the in-flight operation; no write-back is produced.
- `funct3`  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `opa`, `opb`  in  XLEN  rs1/rs2 values; latched at start.
- `rd`  in  6  destination index (matches rf width); latched at start.
- `busy`  out  1  high in CALC and FIX; the core stalls on it.
- `done`  out  1  one-cycle completion pulse.
- `wb_en`  out  1  `done & (wb_rd != 0)`.
- `wb_rd`  out  6  latched `rd`.
- `wb_data`  out  XLEN  result; held until the next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If `start & !flush`, latch operands, `funct3` and `rd`.
  - Signed ops take absolute values and record the result sign. MULHSU treats only `opa` as signed.
  - Go to CALC with counter = 0.
- CALC: one iteration per cycle, XLEN cycles. The counter runs 0..XLEN-1; at XLEN-1 go to FIX.
  - Multiply: radix-2 shift-add into a 2·XLEN product.
  - Divide: restoring; remainder shift/subtract, one quotient bit per cycle.
- FIX:
  - Conditionally negate (two's complement) the 2·XLEN product or the quotient/remainder.
  - Select the result: low half for MUL, high half for MULH/MULHSU/MULHU, quotient or remainder for the divide ops.
  - Register the result into `wb_data`, then go to DONE.
- DONE: assert `done` (and `wb_en` if rd≠0) for one cycle, then go to IDLE unconditionally. `start` is ignored here.
- Special results, which override the datapath:
  - Divide by zero: quotient = all ones; remainder = dividend, unsigned or signed unmodified.
  - Signed overflow (DIV/REM with opa = −2^(XLEN−1), opb = −1): quotient = opa, remainder = 0.
- `flush` in CALC or FIX returns to IDLE on the next edge with no `done`. `flush` in DONE is ignored. `flush` with `start` in IDLE means the start is not accepted.
- `reset` low at any time clears state to IDLE; all outputs and internal registers read 0 immediately.

## Timing
- `start` accepted in cycle 0.
- Normal latency: CALC cycles 1..XLEN, FIX cycle XLEN+1, DONE (`done`/`wb_en` high) cycle XLEN+2, which is 34 for XLEN=32.
- `busy` high cycles 1..XLEN+1 and low in DONE, so the stalled instruction retires in the DONE cycle.
- Write-back data and `wb_rd` are stable during the DONE cycle. The rf captures them at the DONE→IDLE edge.
- The next start can be accepted no earlier than cycle XLEN+3.

## Configuration
- `MULDIV_SPECIAL_FAST_EN` defined:
  - Divide-by-zero and signed-overflow cases go IDLE→DONE directly.
  - `done` in cycle 1; `busy` never asserts.
- Not defined: those cases run the full CALC/FIX sequence, with latency XLEN+2. Results are identical either way.

## Structure
- Package `muldiv_pkg`:
  - Enum `muldiv_state_t` {IDLE, CALC, FIX, DONE}.
  - Localparams for the eight `funct3` encodings.
  - Helper constant `MULDIV_CNT_W = $clog2(XLEN)`.
- Sub-module `muldiv_negate`: parameterised-width conditional two's-complement negator. Instanced for operand absolute values and for result sign fix.

## Test plan
- MUL opa=7, opb=0xFFFFFFFD → `wb_data` 0xFFFFFFEB, `wb_en` at cycle 34, `busy` cycles 1–33.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0x00000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0. `done` at cycle 1 with macro, cycle 34 without.
- MUL with rd=0 → `done` pulses, `wb_en` stays 0. `start` during CALC → ignored; the result is the first op's.
- `flush` at cycle 10 → `busy` low at cycle 11, no `done`; new start at cycle 12 completes normally. `reset` low at cycle 20 → all outputs 0 immediately, IDLE after release.
